// File: rtl/acc_cpu_param_if.sv
// Memory bus of the accumulator core: async-read
// instruction memory plus async-read/sync-write data memory.
interface acc_cpu_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  localparam int INSTR_W = 3 + ADDR_W;

  logic [ADDR_W-1:0]  imem_addr_o;
  logic [INSTR_W-1:0] imem_data_i;
  logic [ADDR_W-1:0]  dmem_addr_o;
  logic [DATA_W-1:0]  dmem_rdata_i;
  logic [DATA_W-1:0]  dmem_wdata_o;
  logic               wm_o;

  modport master (
    output imem_addr_o,
    input  imem_data_i,
    output dmem_addr_o,
    input  dmem_rdata_i,
    output dmem_wdata_o,
    output wm_o
  );

  modport slave (
    input  imem_addr_o,
    output imem_data_i,
    input  dmem_addr_o,
    output dmem_rdata_i,
    input  dmem_wdata_o,
    input  wm_o
  );
endinterface

// File: rtl/acc_cpu_param.sv
// Parametrised accumulator CPU, 3-cycle FETCH/DECODE/EXEC FSM.
// Ports: clk_i, reset (sync, active-low), bus (memories),
// wr_o, reg_acc_out, curr_pc, curr_ins, bus_alu_out,
// flag_z_o, flag_c_o, halted_o.
module acc_cpu_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  localparam int INSTR_W = 3 + ADDR_W
) (
  input  logic               clk_i,
  input  logic               reset,
  acc_cpu_param_if.master    bus,
  output logic               wr_o,
  output logic [DATA_W-1:0]  reg_acc_out,
  output logic [ADDR_W-1:0]  curr_pc,
  output logic [INSTR_W-1:0] curr_ins,
  output logic [DATA_W-1:0]  bus_alu_out,
  output logic               flag_z_o,
  output logic               flag_c_o,
  output logic               halted_o
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    OP_LDA,
    OP_STA,
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_JMP,
    OP_JZ,
    OP_HLT
  } op_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic               z_q, z_d;
  logic               c_q, c_d;

  op_e               op;
  logic [ADDR_W-1:0] opnd;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   dif;
  logic [DATA_W-1:0] alu;
  logic              alu_c;
  logic              wr;
  logic              wm;

  assign op   = op_e'(ir_q[INSTR_W-1 -: 3]);
  assign opnd = ir_q[ADDR_W-1:0];

  // Extra top bit carries the ADD carry-out / SUB borrow.
  assign sum = {1'b0, acc_q} + {1'b0, bus.dmem_rdata_i};
  assign dif = {1'b0, acc_q} - {1'b0, bus.dmem_rdata_i};

  always_comb begin
    alu   = acc_q;
    alu_c = 1'b0;
    case (op)
      OP_LDA: alu = bus.dmem_rdata_i;
      OP_ADD: begin
        alu   = sum[DATA_W-1:0];
        alu_c = sum[DATA_W];
      end
      OP_SUB: begin
        alu   = dif[DATA_W-1:0];
        alu_c = dif[DATA_W];
      end
      OP_AND: alu = acc_q & bus.dmem_rdata_i;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    z_d     = z_q;
    c_d     = c_q;
    wr      = 1'b0;
    wm      = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_d    = bus.imem_data_i;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = (op == OP_HLT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_AND: begin
            wr    = 1'b1;
            acc_d = alu;
            z_d   = (alu == '0);
            c_d   = alu_c;
          end
          OP_STA: wm = 1'b1;
          OP_JMP: pc_d = opnd;
          OP_JZ:  if (z_q) pc_d = opnd;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  // Gating with reset keeps a store from landing mid-reset.
  assign wr_o     = wr & reset;
  assign bus.wm_o = wm & reset;

  assign bus.imem_addr_o  = pc_q;
  assign bus.dmem_addr_o  = opnd;
  assign bus.dmem_wdata_o = acc_q;

  assign reg_acc_out = acc_q;
  assign curr_pc     = pc_q;
  assign curr_ins    = ir_q;
  assign bus_alu_out = alu;
  assign flag_z_o    = z_q;
  assign flag_c_o    = c_q;
  assign halted_o    = (state_q == S_HALT);

endmodule

// File: tb/tb_acc_cpu_param.sv
// Scoreboard bench for acc_cpu_param: owns both memories,
// checks acc writes, stores, flags, pc and halt behaviour.
module tb_acc_cpu_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_o;
  logic [7:0] acc;
  logic [4:0] pc;
  logic [7:0] ins;
  logic [7:0] alu;
  logic       fz;
  logic       fc;
  logic       halted;

  logic [7:0] imem [32];
  logic [7:0] dmem [32];

  typedef struct {
    bit       st;
    bit [4:0] addr;
    bit [7:0] data;
  } ev_t;

  ev_t sbq [$];
  bit  sb_en = 1'b1;
  int  n_cmp = 0;
  int  n_err = 0;
  int  wr_cnt = 0;

  always #5 clk = ~clk;

  acc_cpu_param_if #(.DATA_W(8), .ADDR_W(5)) bus ();

  assign bus.imem_data_i  = imem[bus.imem_addr_o];
  assign bus.dmem_rdata_i = dmem[bus.dmem_addr_o];

  acc_cpu_param #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk_i       (clk),
    .reset       (reset),
    .bus         (bus.master),
    .wr_o        (wr_o),
    .reg_acc_out (acc),
    .curr_pc     (pc),
    .curr_ins    (ins),
    .bus_alu_out (alu),
    .flag_z_o    (fz),
    .flag_c_o    (fc),
    .halted_o    (halted)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_wr(input bit [7:0] d);
    ev_t e;
    e.st = 1'b0; e.addr = '0; e.data = d;
    sbq.push_back(e);
  endtask

  task automatic push_st(input bit [4:0] a,
                         input bit [7:0] d);
    ev_t e;
    e.st = 1'b1; e.addr = a; e.data = d;
    sbq.push_back(e);
  endtask

  // Sample at negedge, apply RAM write at posedge,
  // then return #1 after the edge for input changes.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      logic       we;
      logic [4:0] wa;
      logic [7:0] wd;
      ev_t        e;
      @(negedge clk);
      we = bus.wm_o;
      wa = bus.dmem_addr_o;
      wd = bus.dmem_wdata_o;
      if (wr_o) wr_cnt++;
      if (sb_en && (wr_o || bus.wm_o)) begin
        check("wr_wm_excl", {31'b0, wr_o & bus.wm_o}, 0);
        if (sbq.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sbq.pop_front();
          if (e.st) begin
            check("st_wm", {31'b0, bus.wm_o}, 1);
            check("st_wr", {31'b0, wr_o}, 0);
            check("st_addr", {27'b0, wa}, {27'b0, e.addr});
            check("st_data", {24'b0, wd}, {24'b0, e.data});
          end else begin
            check("wr_flag", {31'b0, wr_o}, 1);
            check("wr_val", {24'b0, alu}, {24'b0, e.data});
          end
        end
      end
      @(posedge clk);
      if (we) dmem[wa] = wd;
      #1;
    end
  endtask

  task automatic boot();
    reset = 1'b0;
    sbq.delete();
    wr_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      imem[i] = 8'hE0;
      dmem[i] = 8'h00;
    end
    cyc(1);
  endtask

  task automatic run_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      cyc(1);
      n++;
    end
    check("halt_reached", {31'b0, halted}, 1);
    check("sb_empty", sbq.size(), 0);
  endtask

  task automatic chk_rst(input string t);
    check({t, "_pc"}, {27'b0, pc}, 0);
    check({t, "_acc"}, {24'b0, acc}, 0);
    check({t, "_z"}, {31'b0, fz}, 0);
    check({t, "_c"}, {31'b0, fc}, 0);
    check({t, "_halt"}, {31'b0, halted}, 0);
    check({t, "_wm"}, {31'b0, bus.wm_o}, 0);
  endtask

  initial begin
    // initial reset state
    boot();
    cyc(1);
    chk_rst("rst0");
    check("rst0_ir", {24'b0, ins}, 0);
    check("rst0_wr", {31'b0, wr_o}, 0);

    // 1: reset held low mid-program
    boot();
    sb_en = 1'b0;
    imem[0] = 8'h10; imem[1] = 8'h51;
    imem[2] = 8'h32; imem[3] = 8'hA1;
    dmem[16] = 8'h01; dmem[17] = 8'h02;
    reset = 1'b1;
    cyc(10);
    reset = 1'b0;
    #1;
    check("t1_wm_async", {31'b0, bus.wm_o}, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk_rst("t1");
    end
    sb_en = 1'b1;

    // 2: LDA, ADD with carry
    boot();
    imem[0] = 8'h10; imem[1] = 8'h51;
    dmem[16] = 8'h05; dmem[17] = 8'hFC;
    push_wr(8'h05); push_wr(8'h01);
    reset = 1'b1;
    cyc(6);
    check("t2_acc", {24'b0, acc}, 8'h01);
    check("t2_c", {31'b0, fc}, 1);
    check("t2_z", {31'b0, fz}, 0);
    run_halt(40);
    check("t2_wrcnt", wr_cnt, 2);

    // 3a: SUB to zero, JZ taken
    boot();
    imem[0] = 8'h12; imem[1] = 8'h73; imem[2] = 8'hC8;
    dmem[18] = 8'h07; dmem[19] = 8'h07;
    push_wr(8'h07); push_wr(8'h00);
    reset = 1'b1;
    cyc(9);
    check("t3a_acc", {24'b0, acc}, 0);
    check("t3a_z", {31'b0, fz}, 1);
    check("t3a_c", {31'b0, fc}, 0);
    check("t3a_pc", {27'b0, pc}, 8);
    run_halt(40);
    check("t3a_pc_h", {27'b0, pc}, 9);

    // 3b: SUB with borrow, JZ not taken
    boot();
    imem[0] = 8'h12; imem[1] = 8'h73; imem[2] = 8'hC8;
    dmem[18] = 8'h07; dmem[19] = 8'h09;
    push_wr(8'h07); push_wr(8'hFE);
    reset = 1'b1;
    cyc(9);
    check("t3b_acc", {24'b0, acc}, 8'hFE);
    check("t3b_z", {31'b0, fz}, 0);
    check("t3b_c", {31'b0, fc}, 1);
    check("t3b_pc", {27'b0, pc}, 3);
    run_halt(40);
    check("t3b_pc_h", {27'b0, pc}, 4);

    // 4a: STA
    boot();
    imem[0] = 8'h14; imem[1] = 8'h32;
    dmem[20] = 8'h5A;
    push_wr(8'h5A); push_st(5'h12, 8'h5A);
    reset = 1'b1;
    run_halt(40);
    check("t4a_ram", {24'b0, dmem[18]}, 8'h5A);
    check("t4a_acc", {24'b0, acc}, 8'h5A);

    // 4b: reset pulsed in the STA EXEC cycle
    boot();
    imem[0] = 8'h14; imem[1] = 8'h32;
    dmem[20] = 8'h5A;
    push_wr(8'h5A);
    reset = 1'b1;
    cyc(5);
    check("t4b_wm_pre", {31'b0, bus.wm_o}, 1);
    reset = 1'b0;
    #1;
    check("t4b_wm", {31'b0, bus.wm_o}, 0);
    cyc(1);
    reset = 1'b1;
    check("t4b_ram", {24'b0, dmem[18]}, 0);
    check("t4b_pc", {27'b0, pc}, 0);
    check("t4b_sb", sbq.size(), 0);

    // 5: JMP to 0x1F, pc wraps
    boot();
    imem[0] = 8'hBF; imem[31] = 8'h15;
    dmem[21] = 8'h3C;
    push_wr(8'h3C);
    reset = 1'b1;
    cyc(3);
    check("t5_pc_jmp", {27'b0, pc}, 5'h1F);
    cyc(1);
    check("t5_pc_wrap", {27'b0, pc}, 0);
    check("t5_ir", {24'b0, ins}, 8'h15);
    imem[0] = 8'hE0;
    cyc(2);
    check("t5_iaddr", {27'b0, bus.imem_addr_o}, 0);
    check("t5_acc", {24'b0, acc}, 8'h3C);
    run_halt(20);
    check("t5_ir_h", {24'b0, ins}, 8'hE0);
    check("t5_pc_h", {27'b0, pc}, 1);

    // 6: HLT freezes, reset restarts
    boot();
    imem[0] = 8'h16; imem[1] = 8'hE0;
    dmem[22] = 8'h77;
    push_wr(8'h77);
    reset = 1'b1;
    cyc(4);
    check("t6_dec", {31'b0, halted}, 0);
    cyc(1);
    check("t6_halt", {31'b0, halted}, 1);
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      check("t6_pc", {27'b0, pc}, 2);
      check("t6_acc", {24'b0, acc}, 8'h77);
      check("t6_hold", {31'b0, halted}, 1);
      check("t6_wmwr", {30'b0, bus.wm_o, wr_o}, 0);
    end
    check("t6_sb", sbq.size(), 0);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    check("t6_rpc", {27'b0, pc}, 0);
    check("t6_rhalt", {31'b0, halted}, 0);
    sbq.delete();
    sb_en = 1'b0;
    cyc(1);
    check("t6_refetch", {27'b0, pc}, 1);
    check("t6_reir", {24'b0, ins}, 8'h16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
